pll_reconfig_sequencer: RTL

//  Shares the single dpll0 reconfiguration engine among NREQ requesters (decim-gain, test port, ...).

---
 rtl/pll_reconfig_sequencer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/pll_reconfig_sequencer.sv
// Round-robin front end that shares one PLL reconfiguration engine among NREQ requesters.
// Each grant runs write_param -> reconfig -> busy handshake -> lock qualification, then ack or err.
module pll_reconfig_sequencer #(
    parameter int NREQ        = 2,
    parameter int DW          = 2,
    parameter int PULSE_LEN   = 2,
    parameter int BUSY_TO     = 64,
    parameter int OP_TO       = 4096,
    parameter int LOCK_STABLE = 16
) (
    input  logic              clk_in,
    input  logic              rst_div2,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   ack,
    output logic              err,
    output logic [2:0]        err_id,
    output logic [DW-1:0]     cfg_data,
    output logic              cfg_write_param,
    output logic              cfg_reconfig,
    input  logic              cfg_busy,
    input  logic              pll_locked,
    output logic              seq_busy,
    output logic [3:0]        dbg_state
);

    localparam int CW = $clog2(OP_TO) + 1;
    localparam int LW = $clog2(LOCK_STABLE + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_WRITE, S_WGAP, S_RECFG, S_WBUSY, S_WIDLE, S_WLOCK, S_DONE, S_FAIL
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [LW-1:0]     lock_cnt_q, lock_cnt_d;
    logic [2:0]        gnt_q, gnt_d, rr_q, rr_d, err_id_q, err_id_d;
    logic [DW-1:0]     data_q, data_d;
    logic              wp_q, wp_d, rc_q, rc_d, err_q, err_d, seq_busy_q, seq_busy_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              busy_m_q, busy_m_d, busy_s_q, busy_s_d;
    logic              lock_m_q, lock_m_d, lock_s_q, lock_s_d;

    logic [2*NREQ-1:0] req_rot;
    logic [3:0]        sum;
    logic              found;
    logic [2:0]        pick;
    logic [DW-1:0]     pick_data;
    logic [2:0]        next_rr;

    // Rotate the request vector by the rr pointer so the first set bit is the next in turn.
    always_comb begin
        req_rot   = {req, req} >> rr_q;
        found     = 1'b0;
        pick      = '0;
        sum       = '0;
        pick_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, rr_q} + 4'(k);
                if (sum >= 4'(NREQ)) sum = sum - 4'(NREQ);
                pick  = sum[2:0];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (pick == 3'(i)) pick_data = req_data[i*DW +: DW];
        end
        next_rr = (gnt_q == 3'(NREQ - 1)) ? 3'd0 : gnt_q + 3'd1;
    end

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        gnt_d      = gnt_q;
        rr_d       = rr_q;
        data_d     = data_q;
        err_id_d   = err_id_q;
        busy_m_d   = cfg_busy;
        busy_s_d   = busy_m_q;
        lock_m_d   = pll_locked;
        lock_s_d   = lock_m_q;
        case (state_q)
            S_IDLE: if (found) begin
                state_d = S_WRITE;
                gnt_d   = pick;
                data_d  = pick_data;
            end
            S_WRITE: if (cnt_q == CW'(PULSE_LEN - 1)) state_d = S_WGAP;
            S_WGAP:  if (!busy_s_q) state_d = S_RECFG;
            S_RECFG: if (cnt_q == CW'(PULSE_LEN - 1)) state_d = S_WBUSY;
            S_WBUSY: begin
                if (busy_s_q)                          state_d = S_WIDLE;
                else if (cnt_q == CW'(BUSY_TO - 1))    state_d = S_FAIL;
            end
            S_WIDLE: begin
                if (!busy_s_q)                         state_d = S_WLOCK;
                else if (cnt_q == CW'(OP_TO - 1))      state_d = S_FAIL;
            end
            S_WLOCK: begin
                lock_cnt_d = lock_s_q ? lock_cnt_q + 1'b1 : '0;
                if (lock_s_q && lock_cnt_q == LW'(LOCK_STABLE - 1)) state_d = S_DONE;
                else if (cnt_q == CW'(OP_TO - 1))                   state_d = S_FAIL;
            end
            S_DONE: begin
                state_d = S_IDLE;
                rr_d    = next_rr;
            end
            S_FAIL: begin
                state_d = S_IDLE;
                rr_d    = next_rr;
            end
            default: state_d = S_IDLE;
        endcase
        // One shared timeout/pulse counter, restarted on every state entry and parked in IDLE.
        if (state_d != state_q || state_q == S_IDLE) begin
            cnt_d      = '0;
            lock_cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        if (state_d == S_FAIL) err_id_d = gnt_q;
        wp_d       = (state_d == S_WRITE);
        rc_d       = (state_d == S_RECFG);
        err_d      = (state_d == S_FAIL);
        seq_busy_d = (state_d != S_IDLE);
        for (int i = 0; i < NREQ; i++) begin
            ack_d[i] = (state_d == S_DONE) && (gnt_q == 3'(i));
        end
    end

    always_ff @(posedge clk_in or negedge rst_div2) begin
        if (!rst_div2) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            lock_cnt_q <= '0;
            gnt_q      <= '0;
            rr_q       <= '0;
            data_q     <= '0;
            err_id_q   <= '0;
            wp_q       <= 1'b0;
            rc_q       <= 1'b0;
            err_q      <= 1'b0;
            seq_busy_q <= 1'b0;
            ack_q      <= '0;
            busy_m_q   <= 1'b0;
            busy_s_q   <= 1'b0;
            lock_m_q   <= 1'b0;
            lock_s_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lock_cnt_q <= lock_cnt_d;
            gnt_q      <= gnt_d;
            rr_q       <= rr_d;
            data_q     <= data_d;
            err_id_q   <= err_id_d;
            wp_q       <= wp_d;
            rc_q       <= rc_d;
            err_q      <= err_d;
            seq_busy_q <= seq_busy_d;
            ack_q      <= ack_d;
            busy_m_q   <= busy_m_d;
            busy_s_q   <= busy_s_d;
            lock_m_q   <= lock_m_d;
            lock_s_q   <= lock_s_d;
        end
    end

    assign ack             = ack_q;
    assign err             = err_q;
    assign err_id          = err_id_q;
    assign cfg_data        = data_q;
    assign cfg_write_param = wp_q;
    assign cfg_reconfig    = rc_q;
    assign seq_busy        = seq_busy_q;
    assign dbg_state       = state_q;

endmodule
